// File: rtl/processor_wrapper_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core.
// Holds the FSM state encodings, opcode/funct constants, pcSelect codes,
// the ALU op enumeration, the NOP word and the instruction decode helpers.
package processor_wrapper_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_AW    = 5;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM    = 4'd3,
        S_WB     = 4'd4
    } state_t;

    typedef enum logic [1:0] {
        PCS_PC4    = 2'd0,
        PCS_BRANCH = 2'd1,
        PCS_JAL    = 2'd2,
        PCS_JALR   = 2'd3
    } pcsel_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_t;

    // Instruction class resolved once in DECODE and carried to later states.
    typedef enum logic [3:0] {
        C_NOP   = 4'd0,
        C_ALU_R = 4'd1,
        C_ALU_I = 4'd2,
        C_LUI   = 4'd3,
        C_LW    = 4'd4,
        C_SW    = 4'd5,
        C_BEQ   = 4'd6,
        C_BNE   = 4'd7,
        C_JAL   = 4'd8,
        C_JALR  = 4'd9
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Anything outside the supported subset collapses to C_NOP.
    function automatic iclass_t decode_class(input logic [6:0] opc,
                                             input logic [2:0] f3,
                                             input logic [6:0] f7);
        iclass_t c;
        c = C_NOP;
        case (opc)
            OP_R: begin
                if (f7 == F7_BASE && f3 inside {F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND})
                    c = C_ALU_R;
                else if (f7 == F7_SUB && f3 == F3_ADD)
                    c = C_ALU_R;
            end
            OP_I:      if (f3 inside {F3_ADD, F3_OR, F3_AND}) c = C_ALU_I;
            OP_LUI:    c = C_LUI;
            OP_LOAD:   if (f3 == F3_LW) c = C_LW;
            OP_STORE:  if (f3 == F3_SW) c = C_SW;
            OP_BRANCH: begin
                if (f3 == F3_BEQ)      c = C_BEQ;
                else if (f3 == F3_BNE) c = C_BNE;
            end
            OP_JAL:    c = C_JAL;
            OP_JALR:   if (f3 == F3_JALR) c = C_JALR;
            default:   c = C_NOP;
        endcase
        return c;
    endfunction

    // Branches compare by subtraction; address/link math uses add.
    function automatic alu_op_t alu_op_of(input iclass_t c,
                                          input logic [2:0] f3,
                                          input logic f7_sub);
        alu_op_t op;
        op = ALU_ADD;
        if (c == C_ALU_R || c == C_ALU_I) begin
            case (f3)
                F3_ADD:  op = (c == C_ALU_R && f7_sub) ? ALU_SUB : ALU_ADD;
                F3_SLT:  op = ALU_SLT;
                F3_XOR:  op = ALU_XOR;
                F3_OR:   op = ALU_OR;
                F3_AND:  op = ALU_AND;
                default: op = ALU_ADD;
            endcase
        end else if (c == C_BEQ || c == C_BNE) begin
            op = ALU_SUB;
        end
        return op;
    endfunction

    // Sign-extended immediate in the format the class uses (bit numbering kept).
    function automatic logic [XLEN-1:0] imm_of(input logic [31:7] ins, input iclass_t c);
        logic [XLEN-1:0] imm;
        case (c)
            C_ALU_I, C_LW, C_JALR: imm = {{20{ins[31]}}, ins[31:20]};
            C_SW:                  imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            C_BEQ, C_BNE:          imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            C_LUI:                 imm = {ins[31:12], 12'b0};
            C_JAL:                 imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:               imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/processor_wrapper_alu.sv
// 32-bit ALU for the processor_wrapper core.
// Ports: a, b   - operands
//        op     - operation select (alu_op_t)
//        result - combinational result
//        zero   - high when result is zero (used for branch compares)
module alu
    import processor_wrapper_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/processor_wrapper.sv
// Multi-cycle RV32I-subset core: FSM, datapath registers, register file,
// instruction ROM and data RAM; the ALU is the only sub-module.
// Ports: clk         - clock, rising edge
//        rst         - synchronous active-high reset
//        pc          - program counter register
//        instruction - instruction register
//        iMemRead    - high while in FETCH
//        cstate      - FSM state encoding
//        pcSelect    - next-PC source (0 pc+4, 1 branch, 2 JAL, 3 JALR)
module processor_wrapper
    import processor_wrapper_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_WORDS = 256,
    parameter string       IMEM_FILE  = "program.hex"
) (
    input  logic             clk,
    input  logic             rst,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  instruction,
    output logic             iMemRead,
    output logic [3:0]       cstate,
    output logic [1:0]       pcSelect
);

    localparam int unsigned IAW = $clog2(IMEM_WORDS);
    localparam int unsigned DAW = $clog2(DMEM_WORDS);

    logic [XLEN-1:0] imem [IMEM_WORDS];
    logic [XLEN-1:0] dmem [DMEM_WORDS];
    logic [XLEN-1:0] regs [REG_COUNT];

    // ROM image: unloaded words read as NOP.
    initial begin
        for (int unsigned i = 0; i < IMEM_WORDS; i++) imem[i] = NOP_INSTR;
    end

    state_t          state;
    pcsel_t          pcsel_q;
    logic            imem_rd;
    logic [XLEN-1:0] pc_q, ir_q, old_pc;
    logic [XLEN-1:0] a_q, b_q, imm_q, res_q;
    iclass_t         cls_q;
    alu_op_t         op_q;
    logic [REG_AW-1:0] rd_q;

    // Decode of the IR and register-file read, consumed in DECODE.
    iclass_t         dec_cls;
    logic [REG_AW-1:0] rs1, rs2;
    logic [XLEN-1:0] rv1, rv2;
    pcsel_t          dec_pcsel;

    always_comb begin
        dec_cls = decode_class(ir_q[6:0], ir_q[14:12], ir_q[31:25]);
        rs1     = ir_q[19:15];
        rs2     = ir_q[24:20];
        rv1     = (rs1 == '0) ? '0 : regs[rs1];
        rv2     = (rs2 == '0) ? '0 : regs[rs2];
        // pcSelect is registered, so the branch outcome is known one state early.
        case (dec_cls)
            C_BEQ:   dec_pcsel = (rv1 == rv2) ? PCS_BRANCH : PCS_PC4;
            C_BNE:   dec_pcsel = (rv1 != rv2) ? PCS_BRANCH : PCS_PC4;
            C_JAL:   dec_pcsel = PCS_JAL;
            C_JALR:  dec_pcsel = PCS_JALR;
            default: dec_pcsel = PCS_PC4;
        endcase
    end

    // ALU operand selection for EXEC.
    logic [XLEN-1:0] alu_a, alu_b, alu_res, target;
    logic            alu_zero, taken;

    always_comb begin
        alu_a  = (cls_q == C_LUI) ? '0 : a_q;
        alu_b  = (cls_q inside {C_ALU_R, C_BEQ, C_BNE}) ? b_q : imm_q;
        target = old_pc + imm_q;
        taken  = (cls_q == C_BEQ) ? alu_zero : !alu_zero;
    end

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (op_q),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // Control FSM and datapath; reset overrides every state and blocks all writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            ir_q    <= NOP_INSTR;
            state   <= S_FETCH;
            pcsel_q <= PCS_PC4;
            imem_rd <= 1'b1;
        end else begin
            case (state)
                S_FETCH: begin
                    ir_q    <= imem[pc_q[IAW+1:2]];
                    old_pc  <= pc_q;
                    pc_q    <= pc_q + 32'd4;
                    pcsel_q <= PCS_PC4;
                    imem_rd <= 1'b0;
                    state   <= S_DECODE;
                end
                S_DECODE: begin
                    a_q   <= rv1;
                    b_q   <= rv2;
                    imm_q <= imm_of(ir_q[31:7], dec_cls);
                    cls_q <= dec_cls;
                    op_q  <= alu_op_of(dec_cls, ir_q[14:12], ir_q[30]);
                    rd_q  <= ir_q[11:7];
                    if (dec_cls == C_NOP) begin
                        imem_rd <= 1'b1;
                        state   <= S_FETCH;
                    end else begin
                        pcsel_q <= dec_pcsel;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    pcsel_q <= PCS_PC4;
                    res_q   <= alu_res;
                    case (cls_q)
                        C_BEQ, C_BNE: begin
                            if (taken) pc_q <= target;
                            imem_rd <= 1'b1;
                            state   <= S_FETCH;
                        end
                        C_JAL: begin
                            pc_q  <= target;
                            res_q <= old_pc + 32'd4;
                            state <= S_WB;
                        end
                        C_JALR: begin
                            pc_q  <= {alu_res[XLEN-1:1], 1'b0};
                            res_q <= old_pc + 32'd4;
                            state <= S_WB;
                        end
                        C_LW, C_SW: state <= S_MEM;
                        default:    state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (cls_q == C_LW) begin
                        res_q <= dmem[res_q[DAW+1:2]];
                        state <= S_WB;
                    end else begin
                        dmem[res_q[DAW+1:2]] <= b_q;
                        imem_rd <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (rd_q != '0) regs[rd_q] <= res_q;
                    imem_rd <= 1'b1;
                    state   <= S_FETCH;
                end
                default: begin
                    pcsel_q <= PCS_PC4;
                    imem_rd <= 1'b1;
                    state   <= S_FETCH;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign instruction = ir_q;
    assign iMemRead    = imem_rd;
    assign cstate      = state;
    assign pcSelect    = pcsel_q;

endmodule

// File: tb/tb_processor_wrapper.sv
// Directed bench for processor_wrapper: loads a small program into the ROM,
// walks it instruction by instruction checking state paths, cycle counts,
// pcSelect, pc and architectural results, then resets in the middle of a store.
module tb_processor_wrapper;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        iMemRead;
    logic [3:0]  cstate;
    logic [1:0]  pcSelect;

    int errors = 0;
    int checks = 0;

    logic [31:0] prog [64];

    processor_wrapper #(
        .IMEM_WORDS (256),
        .DMEM_WORDS (256),
        .IMEM_FILE  ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instruction),
        .iMemRead    (iMemRead),
        .cstate      (cstate),
        .pcSelect    (pcSelect)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from a FETCH negedge until cstate is back at FETCH.
    task automatic exec(input string tag, input logic [31:0] exp_pc, input int exp_cyc,
                        input logic [31:0] exp_path, input logic [1:0] exp_sel);
        logic [31:0] path;
        logic [1:0]  sel;
        logic        bad;
        int          n;
        chk({tag, ".fetch"}, 32'(cstate), 32'd0);
        chk({tag, ".pc"}, pc, exp_pc);
        path = '0;
        sel  = 2'd0;
        bad  = 1'b0;
        n    = 0;
        do begin
            path = (path << 4) | 32'(cstate);
            if (cstate == 4'd2) sel = pcSelect;
            else if (pcSelect != 2'd0) bad = 1'b1;
            if (iMemRead !== (cstate == 4'd0)) bad = 1'b1;
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, ".pc4"}, pc, exp_pc + 32'd4);
                chk({tag, ".ir"}, instruction, prog[exp_pc[7:2]]);
            end
        end while (cstate != 4'd0 && n < 12);
        chk({tag, ".cycles"}, 32'(n), 32'(exp_cyc));
        chk({tag, ".path"}, path, exp_path);
        chk({tag, ".sel"}, 32'(sel), 32'(exp_sel));
        chk({tag, ".idle"}, 32'(bad), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0013;
        prog[0]  = enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);          // ADDI x1,x0,5
        prog[1]  = enc_i(32'd7, 5'd0, 3'b000, 5'd2, 7'b0010011);          // ADDI x2,x0,7
        prog[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);                // ADD x3,x1,x2
        prog[3]  = enc_b(32'd8, 5'd1, 5'd1, 3'b000);                      // BEQ x1,x1,+8
        prog[4]  = enc_i(32'd99, 5'd0, 3'b000, 5'd3, 7'b0010011);         // skipped
        prog[5]  = enc_b(32'd8, 5'd1, 5'd1, 3'b001);                      // BNE x1,x1,+8
        prog[6]  = enc_s(32'd8, 5'd3, 5'd0);                              // SW x3,8(x0)
        prog[7]  = enc_i(32'd8, 5'd0, 3'b010, 5'd4, 7'b0000011);          // LW x4,8(x0)
        prog[8]  = enc_j(32'd16, 5'd5);                                   // JAL x5,+16
        prog[9]  = enc_i(32'hFFFF_FFFF, 5'd4, 3'b000, 5'd7, 7'b0010011);  // ADDI x7,x4,-1
        prog[10] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd9);                // SUB x9,x1,x2
        prog[11] = enc_j(32'd8, 5'd0);                                    // JAL x0,+8
        prog[12] = enc_i(32'd0, 5'd5, 3'b000, 5'd0, 7'b1100111);          // JALR x0,x5,0
        prog[13] = enc_r(7'h00, 5'd1, 5'd9, 3'b010, 5'd10);               // SLT x10,x9,x1
        prog[14] = enc_r(7'h00, 5'd9, 5'd1, 3'b010, 5'd8);                // SLT x8,x1,x9
        prog[15] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd11);               // XOR x11,x1,x2
        prog[16] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd12);               // OR x12,x1,x2
        prog[17] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd13);               // AND x13,x1,x2
        prog[18] = enc_i(32'd3, 5'd2, 3'b111, 5'd14, 7'b0010011);         // ANDI x14,x2,3
        prog[19] = enc_i(32'd8, 5'd1, 3'b110, 5'd15, 7'b0010011);         // ORI x15,x1,8
        prog[20] = {20'h80001, 5'd16, 7'b0110111};                        // LUI x16,0x80001
        prog[21] = enc_i(32'd1, 5'd1, 3'b000, 5'd0, 7'b0010011);          // ADDI x0,x1,1
        prog[22] = enc_r(7'h00, 5'd1, 5'd0, 3'b000, 5'd17);               // ADD x17,x0,x1
        prog[23] = 32'h0000_000B;                                         // unsupported opcode
        prog[24] = enc_s(32'd12, 5'd2, 5'd0);                             // SW x2,12(x0)
        prog[25] = enc_i(32'hFFFF_FFFF, 5'd0, 3'b000, 5'd18, 7'b0010011); // ADDI x18,x0,-1
        prog[26] = enc_s(32'd12, 5'd1, 5'd0);                             // SW x1,12(x0), reset in MEM

        rst = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];

        @(negedge clk);
        chk("rst.pc", pc, 32'd0);
        chk("rst.cstate", 32'(cstate), 32'd0);
        chk("rst.imemread", 32'(iMemRead), 32'd1);
        chk("rst.pcsel", 32'(pcSelect), 32'd0);
        chk("rst.ir", instruction, 32'h0000_0013);
        rst = 1'b0;

        exec("addi1", 32'h00, 4, 32'h0124, 2'd0);
        chk("x1", dut.regs[1], 32'd5);
        exec("addi2", 32'h04, 4, 32'h0124, 2'd0);
        exec("add",   32'h08, 4, 32'h0124, 2'd0);
        chk("x3", dut.regs[3], 32'd12);
        exec("beq",   32'h0C, 3, 32'h012, 2'd1);
        exec("bne",   32'h14, 3, 32'h012, 2'd0);
        exec("sw",    32'h18, 4, 32'h0123, 2'd0);
        chk("dmem2", dut.dmem[2], 32'd12);
        exec("lw",    32'h1C, 5, 32'h01234, 2'd0);
        chk("x4", dut.regs[4], 32'd12);
        exec("jal",   32'h20, 4, 32'h0124, 2'd2);
        chk("x5", dut.regs[5], 32'h24);
        exec("jalr",  32'h30, 4, 32'h0124, 2'd3);
        exec("addi_neg", 32'h24, 4, 32'h0124, 2'd0);
        chk("x7", dut.regs[7], 32'd11);
        exec("sub",   32'h28, 4, 32'h0124, 2'd0);
        chk("x9", dut.regs[9], 32'hFFFF_FFFE);
        exec("jal_x0", 32'h2C, 4, 32'h0124, 2'd2);
        exec("slt_t", 32'h34, 4, 32'h0124, 2'd0);
        chk("x10", dut.regs[10], 32'd1);
        exec("slt_f", 32'h38, 4, 32'h0124, 2'd0);
        chk("x8", dut.regs[8], 32'd0);
        exec("xor",   32'h3C, 4, 32'h0124, 2'd0);
        chk("x11", dut.regs[11], 32'd2);
        exec("or",    32'h40, 4, 32'h0124, 2'd0);
        chk("x12", dut.regs[12], 32'd7);
        exec("and",   32'h44, 4, 32'h0124, 2'd0);
        chk("x13", dut.regs[13], 32'd5);
        exec("andi",  32'h48, 4, 32'h0124, 2'd0);
        chk("x14", dut.regs[14], 32'd3);
        exec("ori",   32'h4C, 4, 32'h0124, 2'd0);
        chk("x15", dut.regs[15], 32'd13);
        exec("lui",   32'h50, 4, 32'h0124, 2'd0);
        chk("x16", dut.regs[16], 32'h8000_1000);
        exec("addi_x0", 32'h54, 4, 32'h0124, 2'd0);
        exec("add_x0", 32'h58, 4, 32'h0124, 2'd0);
        chk("x17", dut.regs[17], 32'd5);
        exec("nop",   32'h5C, 2, 32'h01, 2'd0);
        exec("sw2",   32'h60, 4, 32'h0123, 2'd0);
        chk("dmem3", dut.dmem[3], 32'd7);
        exec("addi_m1", 32'h64, 4, 32'h0124, 2'd0);
        chk("x18", dut.regs[18], 32'hFFFF_FFFF);

        chk("swrst.pc", pc, 32'h68);
        for (int k = 0; k < 8 && cstate != 4'd3; k++) @(negedge clk);
        chk("swrst.mem", 32'(cstate), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("swrst.pc0", pc, 32'd0);
        chk("swrst.cstate", 32'(cstate), 32'd0);
        chk("swrst.imemread", 32'(iMemRead), 32'd1);
        chk("swrst.ir", instruction, 32'h0000_0013);
        chk("swrst.dmem3", dut.dmem[3], 32'd7);
        rst = 1'b0;

        exec("restart", 32'h00, 4, 32'h0124, 2'd0);
        chk("restart.x1", dut.regs[1], 32'd5);
        chk("restart.x3", dut.regs[3], 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/processor_wrapper.md
PROCESSOR_WRAPPER -- requirements
Module: processor_wrapper

Interface
- REQ-001 Parameters, one per line:
  - IMEM_WORDS, 256, instruction ROM depth in 32-bit words.
  - DMEM_WORDS, 256, data RAM depth in 32-bit words.
  - IMEM_FILE, "program.hex", hex image loaded into the instruction ROM at elaboration.
- REQ-002 clk  input  1  single clock; all state updates on the rising edge.
- REQ-003 rst  input  1  reset; synchronous and active-high.
- REQ-004 pc  output  32  current program counter register.
- REQ-005 instruction  output  32  instruction register (IR) contents.
- REQ-006 iMemRead  output  1  high exactly while cstate==FETCH.
- REQ-007 cstate  output  4  current control FSM state encoding.
- REQ-008 pcSelect  output  2  next-PC source: 0=PC+4, 1=branch target, 2=JAL target, 3=JALR target.

Function
- REQ-009 The block SHALL be a multi-cycle RV32I-subset core with internal instruction ROM, data RAM, 32x32 register file and ALU.
- REQ-010 Supported instructions: ADD, SUB, AND, OR, XOR, SLT, ADDI, ANDI, ORI, LUI, LW, SW, BEQ, BNE, JAL, JALR. Any other opcode SHALL execute as a NOP.
- REQ-011 FSM states SHALL be encoded as: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Unused codes 5-15 SHALL go to FETCH.
- REQ-012 FETCH:
  - IR <= IMEM[pc[9:2]].
  - saved PC (oldPC) <= pc.
  - pc <= pc+4.
  - pcSelect=0.
  - next state is DECODE.
- REQ-013 DECODE: read rs1/rs2 and form the immediate (I/S/B/U/J, sign-extended). A NOP goes to FETCH; all other instructions go to EXEC.
- REQ-014 EXEC: compute the ALU result or target. Next state:
  - R-type, I-type, LUI, JAL, JALR: WB.
  - LW, SW: MEM.
  - BEQ, BNE: FETCH.
- REQ-015 Branches: target = oldPC + B-imm. If taken, pcSelect=1 in EXEC and pc <= target at the end of EXEC; if not taken, pcSelect stays 0 and pc is unchanged.
- REQ-016 JAL: pcSelect=2 in EXEC; pc <= oldPC + J-imm at the end of EXEC; rd <= oldPC+4 in WB.
- REQ-017 JALR: pcSelect=3 in EXEC; pc <= (rs1 + I-imm) with bit 0 cleared; rd <= oldPC+4 in WB.
- REQ-018 MEM:
  - LW reads DMEM[addr[9:2]] and goes to WB.
  - SW writes rs2 to DMEM[addr[9:2]] and goes to FETCH.
- REQ-019 WB writes rd and goes to FETCH. Writes to x0 SHALL be discarded; x0 SHALL always read 0.
- REQ-020 pcSelect SHALL be 0 in every state other than EXEC.
- REQ-021 Cycle counts per instruction:
  - taken or untaken branch: 3.
  - R-type, I-type, LUI, JAL, JALR, SW: 4.
  - LW: 5.
  - NOP: 2.
- REQ-022 Arithmetic is 32-bit modulo 2^32. SLT is a signed compare. pc+4 SHALL wrap from 0xFFFFFFFC to 0.
- REQ-023 Memory addressing:
  - Addresses are word-aligned; bits [1:0] SHALL be ignored.
  - Indices wrap modulo depth (pc[9:2], addr[9:2]).
  - IMEM reads beyond the loaded image return 0x00000013 (NOP).

Reset
- REQ-024 While rst=1 at a rising edge:
  - pc <= 0.
  - IR <= 0x00000013.
  - cstate <= FETCH.
  - pcSelect = 0, and iMemRead follows cstate (=1).
- REQ-025 Reset SHALL override any state, including mid-instruction. No register-file or DMEM writes SHALL occur in a cycle where rst=1.
- REQ-026 Register file and DMEM contents SHALL NOT be cleared by reset; a bench must initialise them through the program.

Structure
- REQ-027 A shared package SHALL hold:
  - FSM state encodings.
  - opcode/funct constants.
  - pcSelect codes.
  - ALU-op enumeration.
  - NOP constant 0x00000013.
- REQ-028 The ALU SHALL be one sub-module named alu: 32-bit operands, an op code in, result and zero flag out.
- REQ-029 FSM, datapath registers, register file and memories SHALL live in processor_wrapper.

Verification
- REQ-030 Reset: hold rst=1 for 1 cycle, then release. Required: pc=0, cstate=0, iMemRead=1; the first FETCH loads IR=IMEM[0]; pc=4 one cycle later.
- REQ-031 ALU path: ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2. Required: x3=12; each instruction walks cstate 0,1,2,4; pc=12 after the third instruction.
- REQ-032 Branch: BEQ x1,x1,+8 at pc=12. Required: pcSelect=1 during EXEC; pc=20 in the next FETCH. With BNE x1,x1 instead: pcSelect=0, pc=16.
- REQ-033 Jumps:
  - JAL x5,+16 at pc=0x20: pcSelect=2, pc=0x30, x5=0x24.
  - JALR x0,x5,0: pcSelect=3, pc=0x24, x0 stays 0.
- REQ-034 Memory: SW x3,8(x0) then LW x4,8(x0). Required: x4=12; the LW takes 5 cycles and passes cstate 0,1,2,3,4.
- REQ-035 Reset mid-instruction: assert rst while cstate=MEM of an SW. Required: no DMEM write occurs; pc=0 and cstate=0 next cycle.
